// File: rtl/fetch_if.sv
// Fetch unit bus: CPU control handshake, redirect inputs, BRAM read port
// and the instruction/PC outputs seen by the decoder.
interface fetch_if;
  logic        pc_enable;
  logic        jump_take;
  logic [9:0]  jump_target;
  logic        branch_take;
  logic [7:0]  branch_disp;
  logic [9:0]  mem_addr;
  logic [15:0] mem_q;
  logic [15:0] instr;
  logic        instr_valid;
  logic [9:0]  pc;
  logic [9:0]  pc_plus1;
  logic [15:0] fetch_count;

  // CPU / memory side
  modport master (
    output pc_enable, jump_take, jump_target, branch_take, branch_disp, mem_q,
    input  mem_addr, instr, instr_valid, pc, pc_plus1, fetch_count
  );

  // fetch unit side
  modport slave (
    input  pc_enable, jump_take, jump_target, branch_take, branch_disp, mem_q,
    output mem_addr, instr, instr_valid, pc, pc_plus1, fetch_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: ISSUE/WAIT/HOLD sequencer around a 1-cycle BRAM.
// Optional completed-fetch counter enabled by macro FETCH_COUNT_EN;
// without it fetch_count is tied to zero.
//
// state | meaning
// ISSUE | pc is on mem_addr, BRAM samples it on the next edge
// WAIT  | BRAM data valid on mem_q, captured into instr on the next edge
// HOLD  | instr valid; waits for pc_enable to advance pc
module fetch_unit #(
  parameter logic [9:0] RESET_ADDR = 10'd0
) (
  input logic   clk,
  input logic   rst,
  fetch_if.slave bus
);

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  pc_q, pc_d, next_pc;
  logic [15:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        capture;
  logic        advance;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_ISSUE;
    else      state_q <= state_d;
  end

  // next-state logic; control inputs only matter in HOLD
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_HOLD;
      ST_HOLD:  if (bus.pc_enable) state_d = ST_ISSUE;
      default:  state_d = ST_ISSUE;
    endcase
  end

  // output/strobe decode from the current state
  always_comb begin
    capture = 1'b0;
    advance = 1'b0;
    case (state_q)
      ST_WAIT: capture = 1'b1;
      ST_HOLD: advance = bus.pc_enable;
      default: ;
    endcase
  end

  // redirect priority: jump, then relative branch, then sequential; 10-bit wrap
  always_comb begin
    next_pc = pc_q + 10'd1;
    if (bus.jump_take)        next_pc = bus.jump_target;
    else if (bus.branch_take) next_pc = pc_q + {{2{bus.branch_disp[7]}}, bus.branch_disp};
  end

  // datapath next values
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (capture) begin
      instr_d = bus.mem_q;
      valid_d = 1'b1;
    end
    if (advance) begin
      pc_d    = next_pc;
      valid_d = 1'b0;
    end
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_ADDR;
      instr_q <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

`ifdef FETCH_COUNT_EN
  logic [15:0] count_q;

  // completed-fetch counter, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         count_q <= 16'h0000;
    else if (capture) count_q <= count_q + 16'd1;
  end

  assign bus.fetch_count = count_q;
`else
  assign bus.fetch_count = 16'h0000;
`endif

  assign bus.mem_addr    = pc_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus1    = pc_q + 10'd1;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: BRAM model plus a PC/fetch reference model.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  fetch_if bus ();

  fetch_unit #(.RESET_ADDR(10'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] bram [1024];
  always @(posedge clk) bus.mem_q <= bram[bus.mem_addr];

  int total = 0;
  int bad   = 0;

  // reference model state
  int pc_m    = 0;
  int count_m = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_count();
`ifdef FETCH_COUNT_EN
    return count_m % 65536;
`else
    return 0;
`endif
  endfunction

  task automatic check_hold(input string tag);
    chk({tag, ".valid"}, 32'(bus.instr_valid), 32'd1);
    chk({tag, ".instr"}, 32'(bus.instr), 32'(bram[pc_m]));
    chk({tag, ".pc"}, 32'(bus.pc), 32'(pc_m));
    chk({tag, ".pc_plus1"}, 32'(bus.pc_plus1), 32'((pc_m + 1) % 1024));
    chk({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'(pc_m));
    chk({tag, ".count"}, 32'(bus.fetch_count), 32'(exp_count()));
  endtask

  // one accepted advance from HOLD, then follow the refetch to the next HOLD
  task automatic advance(input string tag, input bit jt, input int tgt,
                         input bit bt, input int disp);
    int d;
    bus.pc_enable   = 1'b1;
    bus.jump_take   = jt;
    bus.jump_target = 10'(tgt);
    bus.branch_take = bt;
    bus.branch_disp = 8'(disp);
    d = (disp >= 128) ? disp - 256 : disp;
    if (jt)      pc_m = tgt % 1024;
    else if (bt) pc_m = (pc_m + d + 1024) % 1024;
    else         pc_m = (pc_m + 1) % 1024;
    step();
    bus.pc_enable   = 1'b0;
    bus.jump_take   = 1'b0;
    bus.branch_take = 1'b0;
    bus.jump_target = 10'h155;
    bus.branch_disp = 8'h55;
    chk({tag, ".acc_valid"}, 32'(bus.instr_valid), 32'd0);
    chk({tag, ".acc_pc"}, 32'(bus.pc), 32'(pc_m));
    step();
    chk({tag, ".wait_valid"}, 32'(bus.instr_valid), 32'd0);
    step();
    count_m++;
    check_hold(tag);
  endtask

  logic [15:0] old_instr;

  initial begin
    for (int i = 0; i < 1024; i++) bram[i] = 16'($urandom);
    bram[0]      = 16'h5321;
    bram[1]      = 16'hA001;
    bram[2]      = 16'hA002;
    bram[3]      = 16'hA003;
    bram[10'h200] = 16'hC0DE;
    bus.pc_enable   = 1'b0;
    bus.jump_take   = 1'b0;
    bus.jump_target = 10'h000;
    bus.branch_take = 1'b0;
    bus.branch_disp = 8'h00;

    // reset state
    #2;
    chk("rst.pc", 32'(bus.pc), 32'd0);
    chk("rst.instr", 32'(bus.instr), 32'd0);
    chk("rst.valid", 32'(bus.instr_valid), 32'd0);
    chk("rst.count", 32'(bus.fetch_count), 32'd0);
    #10 rst = 1'b1;

    // first fetch after reset
    step();
    chk("boot.edge1_valid", 32'(bus.instr_valid), 32'd0);
    step();
    count_m = 1;
    check_hold("boot");

    // sequential run
    advance("seq1", 0, 0, 0, 0);
    advance("seq2", 0, 0, 0, 0);
    advance("seq3", 0, 0, 0, 0);

    // branch and wrap corners
    advance("j10", 1, 10, 0, 0);
    advance("br_m5", 0, 0, 1, 8'hFB);
    advance("j2", 1, 2, 0, 0);
    advance("br_m4", 0, 0, 1, 8'hFC);
    advance("j1023", 1, 1023, 0, 0);
    advance("wrap", 0, 0, 0, 0);
    advance("j4", 1, 4, 0, 0);
    advance("jmp_over_br", 1, 10'h200, 1, 8'h10);
    chk("jmp_over_br.instr_c0de", 32'(bus.instr), 32'hC0DE);

    // controls held during ISSUE and WAIT must be ignored
    bus.pc_enable = 1'b1;
    pc_m = (pc_m + 1) % 1024;
    step();
    bus.jump_take   = 1'b1;
    bus.jump_target = 10'h3FF;
    bus.branch_take = 1'b1;
    step();
    step();
    bus.pc_enable   = 1'b0;
    bus.jump_take   = 1'b0;
    bus.branch_take = 1'b0;
    count_m++;
    check_hold("ignore");
    step();
    chk("ignore.stays_hold", 32'(bus.instr_valid), 32'd1);

    // pc_enable held high: one fetch every three cycles
    bus.pc_enable = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k % 3 == 0) pc_m = (pc_m + 1) % 1024;
      step();
      chk("stream.valid", 32'(bus.instr_valid), (k % 3 == 2) ? 32'd1 : 32'd0);
      chk("stream.pc", 32'(bus.pc), 32'(pc_m));
      if (k % 3 == 2) begin
        count_m++;
        chk("stream.instr", 32'(bus.instr), 32'(bram[pc_m]));
      end
    end
    bus.pc_enable = 1'b0;

    // randomized redirects
    for (int n = 0; n < 40; n++) begin
      advance("rand", 1'($urandom), $urandom_range(0, 1023), 1'($urandom),
              $urandom_range(0, 255));
    end

    // asynchronous reset during WAIT at pc=7
    advance("j7_prep", 1, 6, 0, 0);
    bus.pc_enable = 1'b1;
    pc_m = 7;
    step();
    bus.pc_enable = 1'b0;
    step();
    old_instr = bus.instr;
    chk("rstmid.in_wait", 32'(bus.pc), 32'd7);
    #2 rst = 1'b0;
    #1;
    chk("rstmid.valid", 32'(bus.instr_valid), 32'd0);
    chk("rstmid.pc", 32'(bus.pc), 32'd0);
    chk("rstmid.instr", 32'(bus.instr), 32'd0);
    chk("rstmid.count", 32'(bus.fetch_count), 32'd0);
    @(posedge clk);
    #1;
    chk("rstmid.no_capture", 32'(bus.instr), 32'd0);
    #3 rst = 1'b1;
    pc_m = 0;
    count_m = 0;
    step();
    chk("rstmid.edge1_valid", 32'(bus.instr_valid), 32'd0);
    step();
    count_m = 1;
    check_hold("rstmid.refetch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_ADDR, default 10'd0: PC value loaded on reset.
REQ-002 The block SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port pc_enable, input, 1 bit: advance request from the CPU control FSM.
REQ-005 The block SHALL have port jump_take, input, 1 bit: redirect to jump_target on the accepted advance.
REQ-006 The block SHALL have port jump_target, input, 10 bits: absolute jump address.
REQ-007 The block SHALL have port branch_take, input, 1 bit: apply relative branch on the accepted advance.
REQ-008 The block SHALL have port branch_disp, input, 8 bits: signed two's-complement displacement.
REQ-009 The block SHALL have port mem_addr, output, 10 bits: instruction address driven to the BRAM read port.
REQ-010 The block SHALL have port mem_q, input, 16 bits: BRAM read data, valid one cycle after the address is sampled.
REQ-011 The block SHALL have port instr, output, 16 bits: instruction register feeding the decoder and control FSM.
REQ-012 The block SHALL have port instr_valid, output, 1 bit: instr holds the word at pc.
REQ-013 The block SHALL have port pc, output, 10 bits: current program counter.
REQ-014 The block SHALL have port pc_plus1, output, 10 bits: pc+1 mod 1024, the link value for call instructions.
REQ-015 The block SHALL have port fetch_count, output, 16 bits: completed-fetch counter (see Configuration).

Function
REQ-016 The FSM SHALL have states ISSUE, WAIT and HOLD, with transitions ISSUE->WAIT and WAIT->HOLD unconditionally, and HOLD->ISSUE on pc_enable=1.
REQ-017 mem_addr SHALL equal pc combinationally in all states.
REQ-018 On the WAIT->HOLD edge, instr SHALL load mem_q and instr_valid SHALL go 1.
REQ-019 On the HOLD->ISSUE edge, instr_valid SHALL go 0 and pc SHALL load next_pc, while instr holds its old value.
REQ-020 next_pc priority SHALL be: jump_take -> jump_target; else branch_take -> pc + sign_extend(branch_disp); else pc+1.
REQ-021 All PC arithmetic SHALL be 10-bit modulo 1024, with no saturation: 1023+1=0 and 0+(-1)=1023.
REQ-022 Latency: instr_valid SHALL be 1 exactly two clock edges after the edge that accepts pc_enable.
REQ-023 pc_enable, jump_take and branch_take SHALL be ignored in ISSUE and WAIT, with no queuing.
REQ-024 jump_target and branch_disp SHALL be sampled only on the accepting edge.
REQ-025 When jump_take and branch_take are both 1, the jump SHALL win and the branch SHALL be discarded.
REQ-026 pc_enable held high SHALL yield one advance per HOLD visit, i.e. one fetch every 3 cycles.

Reset
REQ-027 rst=0 SHALL immediately, without a clock, force state=ISSUE, pc=RESET_ADDR, instr=16'h0000, instr_valid=0 and fetch_count=0.
REQ-028 Reset asserted mid-fetch (ISSUE or WAIT) SHALL abort the fetch, with no capture of mem_q.
REQ-029 After rst deasserts, the first rising edge SHALL enter WAIT, and instr_valid SHALL rise on the second edge.

Configuration
REQ-030 When macro FETCH_COUNT_EN is defined, fetch_count SHALL increment by 1 on every WAIT->HOLD edge and wrap 16'hFFFF->16'h0000.
REQ-031 When FETCH_COUNT_EN is undefined, fetch_count SHALL be tied to 16'h0000, with no counter logic inferred and the port list unchanged.

Verification
REQ-032 Reset with RESET_ADDR=0 and BRAM[0]=16'h5321 -> after 2 edges: instr=16'h5321, instr_valid=1, pc=0, pc_plus1=1.
REQ-033 Sequential run: pc_enable pulses in HOLD with BRAM[1..3]=16'hA001..A003 -> instr steps A001, A002, A003, 3 cycles apart, with instr_valid low 2 cycles per step.
REQ-034 At pc=10: branch_take=1 with disp=8'hFB -> pc=5; at pc=2: disp=8'hFC -> pc=1022; at pc=1023: plain advance -> pc=0.
REQ-035 At pc=4: jump_take=1, jump_target=10'h200, branch_take=1, disp=8'h10 -> pc=10'h200, and instr=BRAM[0x200] two edges later.
REQ-036 pc_enable and jump_take pulsed during WAIT -> ignored: pc unchanged and state reaches HOLD normally.
REQ-037 rst pulsed low during WAIT at pc=7 -> instr_valid=0, pc=0 and instr=0 asynchronously; with FETCH_COUNT_EN, fetch_count=0 and then counts 1 after the next capture.
